// File: rtl/mutex_scoreboard.sv
// -----------------------------------------------------------------------------
// mutex_scoreboard
//
// Owns the register/resource mutex vectors of the instructions in the
// pipeline's execute and write slots. The read-stage dependency checker
// consumes these vectors. A vector is captured when the read stage hands an
// instruction to execute. It moves to the write slot when execute advances,
// and it is cleared on retire or on flush. A stall watchdog flags read-stage
// dependency stalls that last too long.
//
// Mutex vector layout: [10] active, [9] memory, [8] eflags,
// [7:0] EDI,ESI,EBP,ESP,EBX,EDX,ECX,EAX.
//
// Ports:
//   clk            in   sole clock, rising edge
//   rst            in   asynchronous active-high reset
//   flush          in   kill the execute slot (exception/branch)
//   rd_accept      in   read stage hands an instruction to execute
//   rd_mutex_next  in   [10:0] mutex vector of that instruction
//   exe_ready      in   execute-slot instruction moves to write
//   wr_finished    in   write-slot instruction retires
//   rd_stall       in   read stage held on a mutex dependency
//   exe_mutex      out  [10:0] execute-slot vector, 0 when empty
//   wr_mutex       out  [10:0] write-slot vector, 0 when empty
//   mutex_current  out  [10:0] exe_mutex | wr_mutex (registers only)
//   stall_count    out  [15:0] consecutive rd_stall cycles, saturating
//   watchdog_fire  out  one-cycle pulse when stall_count reaches the bound
//   protocol_error out  sticky handshake-violation flag
// -----------------------------------------------------------------------------
module mutex_scoreboard #(
  parameter int unsigned WATCHDOG_CYCLES = 1023  // legal range 1..65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        rd_accept,
  input  logic [10:0] rd_mutex_next,
  input  logic        exe_ready,
  input  logic        wr_finished,
  input  logic        rd_stall,
  output logic [10:0] exe_mutex,
  output logic [10:0] wr_mutex,
  output logic [10:0] mutex_current,
  output logic [15:0] stall_count,
  output logic        watchdog_fire,
  output logic        protocol_error
);

  localparam logic [15:0] WD_LIMIT = 16'(WATCHDOG_CYCLES);

  logic        exe_valid;
  logic        wr_valid;
  logic        wr_retire;
  logic        wr_can_accept;
  logic        exe_advance;
  logic        exe_can_accept;
  logic        error_now;
  logic [10:0] exe_next;
  logic [10:0] wr_next;
  logic [15:0] stall_next;

  assign exe_valid      = exe_mutex[10];
  assign wr_valid       = wr_mutex[10];
  assign wr_retire      = wr_finished & wr_valid;
  assign wr_can_accept  = ~wr_valid | wr_retire;
  assign exe_advance    = exe_ready & exe_valid & wr_can_accept;
  assign exe_can_accept = ~exe_valid | exe_advance;

  // Built only from the slot registers. The dependency checker therefore
  // never sees a combinational path from this cycle's handshakes.
  assign mutex_current = exe_mutex | wr_mutex;

  // NOTE: every variable assigned in this always_comb gets a default first.
  // A path that leaves one unassigned infers a latch.
  always_comb begin
    wr_next    = wr_mutex;
    exe_next   = exe_mutex;
    stall_next = 16'h0000;

    // The write slot holds a committed instruction. Flush never touches it.
    if (exe_advance)    wr_next = exe_mutex;
    else if (wr_retire) wr_next = 11'h000;

    // Flush also drops a same-cycle accept. An advance in that same cycle
    // has already moved the old instruction into the write slot above.
    if (flush)                             exe_next = 11'h000;
    else if (rd_accept && exe_can_accept)  exe_next = rd_mutex_next | 11'h400;
    else if (exe_advance)                  exe_next = 11'h000;

    if (rd_stall && !flush) begin
      stall_next = (stall_count == 16'hFFFF) ? stall_count : stall_count + 16'd1;
    end
  end

  // An illegal handshake only raises the flag. The slot logic above already
  // ignores the offending request, so state stays consistent.
  assign error_now = (rd_accept & ~exe_can_accept & ~flush)
                   | (exe_ready & exe_valid & ~wr_can_accept)
                   | (wr_finished & ~wr_valid);

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples values from before the edge, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_mutex      <= 11'h000;
      wr_mutex       <= 11'h000;
      stall_count    <= 16'h0000;
      watchdog_fire  <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      exe_mutex      <= exe_next;
      wr_mutex       <= wr_next;
      stall_count    <= stall_next;
      // Fire only on the edge where the count first lands on the bound. A
      // count saturated at the bound does not re-fire until it is cleared.
      watchdog_fire  <= (stall_next == WD_LIMIT) && (stall_count != WD_LIMIT);
      protocol_error <= protocol_error | error_now;
    end
  end

endmodule

// File: tb/tb_mutex_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_mutex_scoreboard
//
// Self-checking bench for mutex_scoreboard with WATCHDOG_CYCLES = 4. Each
// stimulus cycle pushes its hand-derived expected outputs onto a scoreboard
// queue. The entry is popped and compared 1 ns after the rising edge that
// completes that cycle.
// -----------------------------------------------------------------------------
module tb_mutex_scoreboard;

  typedef struct {
    logic [10:0] exe;
    logic [10:0] wr;
    logic        perr;
    logic [15:0] stall;
    logic        wd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        rd_accept;
  logic [10:0] rd_mutex_next;
  logic        exe_ready;
  logic        wr_finished;
  logic        rd_stall;
  logic [10:0] exe_mutex;
  logic [10:0] wr_mutex;
  logic [10:0] mutex_current;
  logic [15:0] stall_count;
  logic        watchdog_fire;
  logic        protocol_error;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   wd_pulses = 0;

  mutex_scoreboard #(.WATCHDOG_CYCLES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .rd_accept      (rd_accept),
    .rd_mutex_next  (rd_mutex_next),
    .exe_ready      (exe_ready),
    .wr_finished    (wr_finished),
    .rd_stall       (rd_stall),
    .exe_mutex      (exe_mutex),
    .wr_mutex       (wr_mutex),
    .mutex_current  (mutex_current),
    .stall_count    (stall_count),
    .watchdog_fire  (watchdog_fire),
    .protocol_error (protocol_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".exe"},   16'(exe_mutex),     16'(e.exe));
    check({tag, ".wr"},    16'(wr_mutex),      16'(e.wr));
    check({tag, ".cur"},   16'(mutex_current), 16'(e.exe | e.wr));
    check({tag, ".perr"},  16'(protocol_error), 16'(e.perr));
    check({tag, ".stall"}, stall_count,        e.stall);
    check({tag, ".wd"},    16'(watchdog_fire), 16'(e.wd));
  endtask

  // One clock cycle of stimulus. The expectation is queued when the inputs
  // are driven and compared once the edge has been taken.
  task automatic cyc(input string tag, input logic fl, input logic ra, input logic [10:0] rv,
                     input logic er, input logic wf, input logic rs,
                     input logic [10:0] e_exe, input logic [10:0] e_wr, input logic e_perr,
                     input logic [15:0] e_stall, input logic e_wd);
    exp_t e;
    e.exe = e_exe; e.wr = e_wr; e.perr = e_perr; e.stall = e_stall; e.wd = e_wd;
    exp_q.push_back(e);
    flush = fl; rd_accept = ra; rd_mutex_next = rv;
    exe_ready = er; wr_finished = wf; rd_stall = rs;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, ".queue"}, 16'd0, 16'd1);
    end else begin
      check_all(tag, exp_q.pop_front());
    end
    if (watchdog_fire) wd_pulses++;
  endtask

  initial begin
    exp_t z;
    z.exe = '0; z.wr = '0; z.perr = 1'b0; z.stall = '0; z.wd = 1'b0;

    rst = 1'b1; flush = 0; rd_accept = 0; rd_mutex_next = '0;
    exe_ready = 0; wr_finished = 0; rd_stall = 0;
    #12;
    check_all("reset", z);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // The accept forces the active bit.
    cyc("acc1",    0,1,11'h001, 0,0,0, 11'h401,11'h000,0, 0,0);
    cyc("adv1",    0,0,11'h000, 1,0,0, 11'h000,11'h401,0, 0,0);
    cyc("ret1",    0,0,11'h000, 0,1,0, 11'h000,11'h000,0, 0,0);
    // Fill wr = 410 and exe = 404, then retire, advance and accept together.
    cyc("acc2",    0,1,11'h010, 0,0,0, 11'h410,11'h000,0, 0,0);
    cyc("fill",    0,1,11'h004, 1,0,0, 11'h404,11'h410,0, 0,0);
    cyc("triple",  0,1,11'h080, 1,1,0, 11'h480,11'h404,0, 0,0);
    // Flush empties exe. wr is untouched.
    cyc("fl1",     1,0,11'h000, 0,0,0, 11'h000,11'h404,0, 0,0);
    cyc("acc3",    0,1,11'h002, 0,0,0, 11'h402,11'h404,0, 0,0);
    cyc("fl_acc",  1,1,11'h001, 0,0,0, 11'h000,11'h404,0, 0,0);
    // Flush with a same-cycle advance still moves exe into wr.
    cyc("acc4",    0,1,11'h108, 0,0,0, 11'h508,11'h404,0, 0,0);
    cyc("fl_adv",  1,0,11'h000, 1,1,0, 11'h000,11'h508,0, 0,0);
    // Both slots full and no retire: exe_ready is a violation, and both hold.
    cyc("acc5",    0,1,11'h020, 0,0,0, 11'h420,11'h508,0, 0,0);
    cyc("perr",    0,0,11'h000, 1,0,0, 11'h420,11'h508,1, 0,0);
    cyc("perr_st", 0,0,11'h000, 0,0,0, 11'h420,11'h508,1, 0,0);

    // Watchdog: stall held for 10 cycles. The bound is 4.
    for (int k = 1; k <= 10; k++) begin
      cyc("stall", 0,0,11'h000, 0,0,1, 11'h420,11'h508,1, 16'(k), (k == 4));
    end
    check("wd_pulses", 16'(wd_pulses), 16'd1);
    cyc("stall_drop", 0,0,11'h000, 0,0,0, 11'h420,11'h508,1, 0,0);
    cyc("stall_a",    0,0,11'h000, 0,0,1, 11'h420,11'h508,1, 1,0);
    cyc("stall_fl",   1,0,11'h000, 0,0,1, 11'h000,11'h508,1, 0,0);
    cyc("refill",     0,1,11'h040, 0,0,0, 11'h440,11'h508,1, 0,0);

    // Async reset between edges with both slots full.
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", z);
    @(posedge clk);
    #1;
    check_all("rst_hold", z);
    @(negedge clk);
    rst = 1'b0;
    #1;
    cyc("post_rst", 0,0,11'h000, 0,0,0, 11'h000,11'h000,0, 0,0);
    // Retiring an empty write slot is a violation that changes no state.
    cyc("wf_empty", 0,0,11'h000, 0,1,0, 11'h000,11'h000,1, 0,0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mutex_scoreboard.md
# mutex_scoreboard

Sequential owner of the pipeline register/resource mutex vectors consumed by the read-stage dependency checker. It captures the 11-bit mutex vector of each instruction leaving the read stage, carries it through the execute and write slots in step with the pipeline handshakes, and clears it on retire or flush. Its `exe_mutex`/`wr_mutex` outputs feed the read-stage busy logic. A stall watchdog flags read-stage dependency stalls that exceed a bound.

## Interface
Parameters:
- `WATCHDOG_CYCLES`, default 1023: consecutive read-stall cycles that trigger `watchdog_fire`; legal range 1..65535.

Ports:
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: pipeline flush (exception/branch); kills the execute slot.
- `rd_accept` in 1: read stage hands an instruction to execute this cycle.
- `rd_mutex_next` in 11: mutex vector of the accepted instruction. Bit 10 is active, 9 memory, 8 eflags, 7..0 EDI,ESI,EBP,ESP,EBX,EDX,ECX,EAX.
- `exe_ready` in 1: execute slot instruction moves to write this cycle.
- `wr_finished` in 1: write slot instruction retires this cycle.
- `rd_stall` in 1: read stage held on a mutex dependency this cycle.
- `exe_mutex` out 11: registered mutex of the execute-slot instruction; 0 when empty.
- `wr_mutex` out 11: registered mutex of the write-slot instruction; 0 when empty.
- `mutex_current` out 11: combinational `exe_mutex | wr_mutex`.
- `stall_count` out 16: consecutive `rd_stall` cycles, saturating.
- `watchdog_fire` out 1: one-cycle pulse.
- `protocol_error` out 1: sticky; cleared only by `rst`.

## Operation
- Slot valid = bit 10 of the slot vector.
- Execute slot can accept when it is empty or advancing. Advancing means `exe_ready & exe_valid & wr_can_accept`.
- Write slot can accept when it is empty or `wr_finished & wr_valid`.
- Write slot, priority high to low:
  - exe advance: `wr_mutex <= exe_mutex`.
  - `wr_finished & wr_valid`: `wr_mutex <= 0`.
  - Otherwise: hold.
- Execute slot, priority high to low:
  - `flush`: `exe_mutex <= 0`, and any same-cycle `rd_accept` is dropped. The write slot is unaffected because its instruction is committed. A same-cycle exe advance still completes into the write slot.
  - `rd_accept & exe_can_accept`: `exe_mutex <= {1'b1, rd_mutex_next[9:0]}`. Bit 10 is forced to 1.
  - exe advance: `exe_mutex <= 0`.
  - Otherwise: hold.
- Protocol violations set `protocol_error`:
  - `rd_accept` while the execute slot cannot accept and `flush` is low. The accept is ignored and the slot holds.
  - `exe_ready` while the execute slot is valid and the write slot cannot accept. The slot holds.
  - `wr_finished` while the write slot is empty. No state change.
- Stall counter:
  - `rd_stall` high: `stall_count <= sat(stall_count+1)`, saturating at 16'hFFFF.
  - `rd_stall` low or `flush`: `stall_count <= 0`.
- Watchdog: `watchdog_fire` is registered, and high for exactly the one cycle after `stall_count` transitions to `WATCHDOG_CYCLES`. It does not re-fire until the counter has been cleared.

## Timing
- Reset values: `exe_mutex`, `wr_mutex`, `stall_count`, `watchdog_fire` and `protocol_error` are all 0.
- Latency:
  - `rd_accept` edge n: `exe_mutex` valid from cycle n+1.
  - Exe advance at n: `wr_mutex` updated at n+1.
  - Retire at n: `wr_mutex` = 0 at n+1.
- Back-to-back throughput is one instruction per cycle. Retire, exe advance and `rd_accept` may all occur in the same cycle, and all three complete.
- `mutex_current` has zero latency from the registers and must not depend combinationally on any input.
- Reset asserted mid-operation clears all state immediately and asynchronously. Outputs stay at reset values until the first edge after deassertion.

## Test plan
- Reset, then `rd_accept` with `rd_mutex_next`=11'h001 -> `exe_mutex`=11'h401 next cycle, `mutex_current`=11'h401.
- Fill exe with 11'h404 and wr with 11'h410, then assert `wr_finished`, `exe_ready` and `rd_accept` (vector 11'h080) in one cycle -> next cycle `wr_mutex`=11'h404, `exe_mutex`=11'h480, `protocol_error`=0.
- Exe 11'h402 valid, then `flush` with `rd_accept` (vector 11'h001) and no `exe_ready` -> `exe_mutex`=0, `wr_mutex` unchanged, new vector dropped.
- Exe and wr both full with no retire, then `exe_ready` -> both slots hold and `protocol_error`=1, remaining 1 until `rst`.
- `WATCHDOG_CYCLES`=4 and `rd_stall` held 10 cycles -> `stall_count` reaches 4, `watchdog_fire` pulses once for one cycle. Dropping `rd_stall` -> `stall_count`=0.
- Async `rst` pulse between clock edges with both slots full -> outputs 0 before the next edge.
